ft600_bus_sched: RTL and testbench
==================================

FT600_BUS_SCHED -- requirements
Module: ft600_bus_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FT600 data-bus width.
REQ-002 SHALL have parameter MAX_BURST, default 256, maximum words per bus grant (range 2..65535).
REQ-003 SHALL have ports CLK in 1, single clock (FT600 interface clock), and nRST in 1, reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have ports usb_rxf_n in 1, FT600 read data available, active-low; usb_txe_n in 1, FT600 write space available, active-low.
REQ-005 SHALL have ports usb_oe_n out 1, FT600 output enable; usb_rd_n out 1, read strobe; usb_wr_n out 1, write strobe (all active-low).
REQ-006 SHALL have ports usb_din in DATA_W, bus sample from I/O buffer; usb_dout out DATA_W, bus drive value; usb_drive out 1, I/O buffer drive enable (1 = block drives bus).
REQ-007 SHALL have ports rx_valid out 1, rx_data out DATA_W, rx_ready in 1: received-word stream, transfer when valid and ready both high.
REQ-008 SHALL have ports tx_valid in 1, tx_data in DATA_W, tx_ready out 1: transmit-word stream, transfer when valid and ready both high.
REQ-009 SHALL have ports busy out 1, state not IDLE; rx_count out 32, tx_count out 32, wrapping word counters.

Function
REQ-010 SHALL implement states IDLE, RD_OE, RD, WR, TURN; usb_oe_n, usb_rd_n and usb_drive registered, decoded from next state.
REQ-011 SHALL contain a 4-entry rx FIFO between the bus and the rx stream; rx_valid = FIFO non-empty, rx_data = head entry, first-word fall-through.
REQ-012 In IDLE: rd_req = !usb_rxf_n and rx FIFO has at least 2 free entries; wr_req = !usb_txe_n and tx_valid.
REQ-013 Arbitration: only rd_req -> RD_OE; only wr_req -> WR; both -> direction opposite to last_dir (round-robin); neither -> stay IDLE.
REQ-014 last_dir SHALL update on every IDLE grant; reset value = WR, so the first contended grant goes to read.
REQ-015 RD_OE: exactly 1 cycle, usb_oe_n=0, usb_rd_n=1, usb_drive=0 (bus turnaround); then RD unconditionally.
REQ-016 RD: usb_oe_n=0, usb_rd_n=0; a word SHALL be captured from usb_din into the rx FIFO on every RD cycle with usb_rxf_n=0.
REQ-017 RD exit to TURN when: usb_rxf_n=1, or burst count reaches MAX_BURST with this cycle's capture, or rx FIFO free entries after this cycle's capture and pop reach 0; the rx FIFO SHALL never overflow.
REQ-018 WR: usb_drive=1, usb_oe_n=1, usb_dout=tx_data; usb_wr_n = !(state==WR and tx_valid), combinational; tx_ready = state==WR and !usb_txe_n.
REQ-019 WR exit to TURN when: usb_txe_n=1, tx_valid=0, or burst count reaches MAX_BURST with this cycle's transfer.
REQ-020 TURN: exactly 1 cycle, all strobes high, usb_drive=0; then IDLE.
REQ-021 Burst counter SHALL clear on IDLE grant and increment once per captured or transmitted word.
REQ-022 rx_count SHALL increment on each rx FIFO push; tx_count on each tx transfer; both wrap 2^32-1 -> 0.
REQ-023 Simultaneous rx FIFO push and pop SHALL leave occupancy unchanged.
REQ-024 usb_drive and usb_oe_n=0 SHALL never both be active in the same cycle; at least one cycle with neither SHALL separate read and write phases.

Reset
REQ-025 With nRST=0 at a clock edge: state=IDLE, usb_oe_n=1, usb_rd_n=1, usb_wr_n=1, usb_drive=0, tx_ready=0, rx FIFO empty (rx_valid=0), burst counter 0, rx_count=0, tx_count=0, last_dir=WR, busy=0.
REQ-026 Reset asserted mid-burst SHALL abort the burst at the next edge with REQ-025 values; the word on the bus that cycle is discarded and not counted.

Verification
REQ-027 Read only: rxf_n low 10 cycles, rx_ready=1, txe_n high -> RD_OE 1 cycle, then 10 words captured in order, rx_count=10, TURN, IDLE.
REQ-028 Backpressure: rx_ready=0, rxf_n held low -> exactly 4 words captured, rd_n high, no overflow; rx_ready=1 -> 4 words delivered in order, a new burst starts.
REQ-029 Contention: rxf_n low, txe_n low, tx_valid=1 continuously, MAX_BURST=4 -> grants alternate RD,WR,RD,...; each burst 4 words; each switch has an idle turnaround cycle.
REQ-030 Write stall: 3-word tx burst with txe_n rising after word 2 -> wr_n high the next cycle, tx_count=2, word 3 stays pending and goes in the next grant.
REQ-031 Reset mid-read (after word 5 of 10) -> next edge all strobes high, rx_valid=0, counters 0; rd_n high for the whole reset.
REQ-032 Counter wrap: tx_count preset via 2^32-1 transfers (or force) -> one more transfer gives 0.

Source files
------------

// File: rtl/ft600_bus_sched.sv
// FT600 245-style synchronous FIFO bus scheduler: arbitrates the shared data bus
// between read bursts (into a 4-deep rx FIFO) and write bursts (from the tx stream).
module ft600_bus_sched #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 256
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              usb_rxf_n,
    input  logic              usb_txe_n,
    output logic              usb_oe_n,
    output logic              usb_rd_n,
    output logic              usb_wr_n,
    input  logic [DATA_W-1:0] usb_din,
    output logic [DATA_W-1:0] usb_dout,
    output logic              usb_drive,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              busy,
    output logic [31:0]       rx_count,
    output logic [31:0]       tx_count
);
    typedef enum logic [2:0] {S_IDLE, S_RD_OE, S_RD, S_WR, S_TURN} state_t;

    localparam logic        DIR_RD    = 1'b0;
    localparam logic        DIR_WR    = 1'b1;
    localparam logic [15:0] BURST_MAX = 16'(MAX_BURST);

    state_t            state_q, state_d;
    logic              last_dir_q, last_dir_d;
    logic [15:0]       burst_q, burst_d;
    logic              oe_n_q, oe_n_d, rd_n_q, rd_n_d, drive_q, drive_d;
    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]        level_q, level_d;
    logic [31:0]       rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    logic              push, pop, tx_xfer, rd_req, wr_req, burst_last;
    logic [2:0]        level_after;

    assign push        = (state_q == S_RD) && !usb_rxf_n;
    assign pop         = (level_q != 3'd0) && rx_ready;
    assign tx_ready    = (state_q == S_WR) && !usb_txe_n;
    assign tx_xfer     = tx_ready && tx_valid;
    assign usb_wr_n    = !((state_q == S_WR) && tx_valid);
    assign usb_dout    = tx_data;
    assign level_after = level_q + {2'b00, push} - {2'b00, pop};
    assign burst_last  = (burst_q + 16'd1) == BURST_MAX;
    // Two free slots guarantee the RD_OE cycle plus the first capture can never overflow.
    assign rd_req      = !usb_rxf_n && (level_q <= 3'd2);
    assign wr_req      = !usb_txe_n && tx_valid;

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        burst_d    = burst_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req && (!wr_req || last_dir_q == DIR_WR)) begin
                    state_d    = S_RD_OE;
                    last_dir_d = DIR_RD;
                    burst_d    = '0;
                end else if (wr_req) begin
                    state_d    = S_WR;
                    last_dir_d = DIR_WR;
                    burst_d    = '0;
                end
            end
            S_RD_OE: state_d = S_RD;
            S_RD: begin
                if (push) burst_d = burst_q + 16'd1;
                if (usb_rxf_n || (push && burst_last) || level_after == 3'd4) state_d = S_TURN;
            end
            S_WR: begin
                if (tx_xfer) burst_d = burst_q + 16'd1;
                if (usb_txe_n || !tx_valid || (tx_xfer && burst_last)) state_d = S_TURN;
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        oe_n_d     = !(state_d == S_RD_OE || state_d == S_RD);
        rd_n_d     = !(state_d == S_RD);
        drive_d    = (state_d == S_WR);
        wr_ptr_d   = wr_ptr_q + {1'b0, push};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        level_d    = level_after;
        rx_count_d = rx_count_q + {31'd0, push};
        tx_count_d = tx_count_q + {31'd0, tx_xfer};
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            last_dir_q <= DIR_WR;
            burst_q    <= '0;
            oe_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            drive_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            burst_q    <= burst_d;
            oe_n_q     <= oe_n_d;
            rd_n_q     <= rd_n_d;
            drive_q    <= drive_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
        end
    end

    // Storage needs no reset; pointers and level define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr_q] <= usb_din;
    end

    assign usb_oe_n  = oe_n_q;
    assign usb_rd_n  = rd_n_q;
    assign usb_drive = drive_q;
    assign rx_valid  = (level_q != 3'd0);
    assign rx_data   = fifo_mem[rd_ptr_q];
    assign busy      = (state_q != S_IDLE);
    assign rx_count  = rx_count_q;
    assign tx_count  = tx_count_q;
endmodule

// File: tb/tb_ft600_bus_sched.sv
// Bench for ft600_bus_sched: behavioural FT600 bus model plus rx/tx scoreboards.
module tb_ft600_bus_sched;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, use4, rx_ready, cont_chk;
    int rx_supplied = 0, rx_taken = 0, tx_total = 0, tx_sent = 0, tx_space = 0, tx_taken = 0;
    logic [DW-1:0] ft_word = 16'h1000;
    logic [DW-1:0] tx_mem [256];

    wire usb_rxf_n = (rx_taken >= rx_supplied);
    wire usb_txe_n = (tx_taken >= tx_space);
    wire tx_valid  = (tx_sent < tx_total);
    wire [DW-1:0] tx_data = tx_mem[tx_sent[7:0]];

    logic a_oe_n, a_rd_n, a_wr_n, a_drive, a_rx_valid, a_tx_ready, a_busy;
    logic b_oe_n, b_rd_n, b_wr_n, b_drive, b_rx_valid, b_tx_ready, b_busy;
    logic [DW-1:0] a_dout, a_rx_data, b_dout, b_rx_data;
    logic [31:0] a_rx_count, a_tx_count, b_rx_count, b_tx_count;

    ft600_bus_sched #(.DATA_W(DW)) u_dut (
        .CLK(clk), .nRST(nrst), .usb_rxf_n(usb_rxf_n), .usb_txe_n(usb_txe_n),
        .usb_oe_n(a_oe_n), .usb_rd_n(a_rd_n), .usb_wr_n(a_wr_n), .usb_din(ft_word),
        .usb_dout(a_dout), .usb_drive(a_drive), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
        .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(a_tx_ready),
        .busy(a_busy), .rx_count(a_rx_count), .tx_count(a_tx_count));

    ft600_bus_sched #(.DATA_W(DW), .MAX_BURST(4)) u_dut4 (
        .CLK(clk), .nRST(nrst), .usb_rxf_n(usb_rxf_n), .usb_txe_n(usb_txe_n),
        .usb_oe_n(b_oe_n), .usb_rd_n(b_rd_n), .usb_wr_n(b_wr_n), .usb_din(ft_word),
        .usb_dout(b_dout), .usb_drive(b_drive), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(b_tx_ready),
        .busy(b_busy), .rx_count(b_rx_count), .tx_count(b_tx_count));

    // The bus model talks to whichever instance is selected.
    wire obs_oe_n = use4 ? b_oe_n : a_oe_n;
    wire obs_rd_n = use4 ? b_rd_n : a_rd_n;
    wire obs_wr_n = use4 ? b_wr_n : a_wr_n;
    wire obs_drive = use4 ? b_drive : a_drive;
    wire obs_rx_valid = use4 ? b_rx_valid : a_rx_valid;
    wire obs_tx_ready = use4 ? b_tx_ready : a_tx_ready;
    wire obs_busy = use4 ? b_busy : a_busy;
    wire [DW-1:0] obs_dout = use4 ? b_dout : a_dout;
    wire [DW-1:0] obs_rx_data = use4 ? b_rx_data : a_rx_data;
    wire [31:0] obs_rx_count = use4 ? b_rx_count : a_rx_count;
    wire [31:0] obs_tx_count = use4 ? b_tx_count : a_tx_count;

    int n_vec = 0, n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int i;
        i = 0;
        while (obs_busy && i < lim) begin
            tick();
            i++;
        end
        check_val(tag, {31'd0, obs_busy}, 32'd0);
    endtask

    // FT600 device side: consumes a word per read strobe, accepts a word per write strobe.
    always @(posedge clk) begin
        if (!obs_rd_n && !usb_rxf_n) begin
            rx_taken <= rx_taken + 1;
            ft_word  <= ft_word + 16'h0123;
        end
        if (!obs_wr_n && !usb_txe_n) tx_taken <= tx_taken + 1;
        if (tx_valid && obs_tx_ready) tx_sent <= tx_sent + 1;
    end

    logic [DW-1:0] rx_exp[$];
    logic [DW-1:0] tx_exp[$];
    int   exp_rx_count, gap, burst_words, n_bursts;
    logic busy_prev, exp_dir;

    always @(negedge clk) begin
        if (!nrst) begin
            rx_exp.delete();
            tx_exp.delete();
            exp_rx_count = 0;
            busy_prev = 1'b0;
            gap = 0;
            burst_words = 0;
            exp_dir = 1'b0;
            n_bursts = 0;
        end else begin
            check_val("no_overlap", {31'd0, !obs_oe_n && obs_drive}, 32'd0);
            if (!obs_rd_n && !usb_rxf_n) begin
                rx_exp.push_back(ft_word);
                exp_rx_count++;
            end
            if (obs_rx_valid && rx_ready) begin
                if (rx_exp.size() == 0) check_val("rx_extra", 32'd1, 32'd0);
                else check_val("rx_data", {16'd0, obs_rx_data}, {16'd0, rx_exp.pop_front()});
            end
            if (tx_valid && obs_tx_ready) tx_exp.push_back(tx_data);
            if (!obs_wr_n && !usb_txe_n) begin
                check_val("wr_drive", {31'd0, obs_drive}, 32'd1);
                if (tx_exp.size() == 0) check_val("tx_extra", 32'd1, 32'd0);
                else check_val("tx_data", {16'd0, obs_dout}, {16'd0, tx_exp.pop_front()});
            end
            if (cont_chk) begin
                if (obs_busy && !busy_prev) begin
                    check_val("turn_gap", {31'd0, gap != 0}, 32'd1);
                    check_val("grant_dir", {31'd0, obs_drive}, {31'd0, exp_dir});
                    exp_dir = !exp_dir;
                    burst_words = 0;
                end
                if ((!obs_rd_n && !usb_rxf_n) || (!obs_wr_n && !usb_txe_n)) burst_words++;
                if (!obs_busy && busy_prev) begin
                    check_val("burst_len", burst_words, 32'd4);
                    n_bursts++;
                end
                gap = (obs_oe_n && !obs_drive) ? gap + 1 : 0;
                busy_prev = obs_busy;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, i;
        nrst = 1'b0; use4 = 1'b0; cont_chk = 1'b0; rx_ready = 1'b1;
        for (int k = 0; k < 256; k++) tx_mem[k] = DW'($urandom);
        // Reset state with both directions requesting.
        rx_supplied = 4; tx_space = 4; tx_total = 2;
        repeat (3) tick();
        check_val("rst_oe_n", {31'd0, a_oe_n}, 32'd1);
        check_val("rst_rd_n", {31'd0, a_rd_n}, 32'd1);
        check_val("rst_wr_n", {31'd0, a_wr_n}, 32'd1);
        check_val("rst_drive", {31'd0, a_drive}, 32'd0);
        check_val("rst_tx_ready", {31'd0, a_tx_ready}, 32'd0);
        check_val("rst_rx_valid", {31'd0, a_rx_valid}, 32'd0);
        check_val("rst_busy", {31'd0, a_busy}, 32'd0);
        check_val("rst_rx_count", a_rx_count, 32'd0);
        check_val("rst_tx_count", a_tx_count, 32'd0);
        rx_supplied = rx_taken; tx_space = tx_taken; tx_total = tx_sent;
        tick(); nrst = 1'b1; tick();

        // Read-only 10-word burst.
        base = rx_taken;
        rx_supplied = base + 10;
        tick();
        check_val("rdoe_busy", {31'd0, obs_busy}, 32'd1);
        check_val("rdoe_oe_n", {31'd0, obs_oe_n}, 32'd0);
        check_val("rdoe_rd_n", {31'd0, obs_rd_n}, 32'd1);
        check_val("rdoe_drive", {31'd0, obs_drive}, 32'd0);
        tick();
        check_val("rd_rd_n", {31'd0, obs_rd_n}, 32'd0);
        wait_idle("rd10_idle", 40);
        check_val("rd10_taken", rx_taken - base, 32'd10);
        check_val("rd10_rx_count", obs_rx_count, 32'd10);
        repeat (4) tick();
        check_val("rd10_drained", {31'd0, obs_rx_valid}, 32'd0);

        // Backpressure: FIFO fills to exactly 4, then drains in order.
        rx_ready = 1'b0;
        base = rx_taken;
        rx_supplied = base + 100;
        repeat (20) tick();
        check_val("bp_words", rx_taken - base, 32'd4);
        check_val("bp_rd_n", {31'd0, obs_rd_n}, 32'd1);
        check_val("bp_rx_valid", {31'd0, obs_rx_valid}, 32'd1);
        check_val("bp_rx_count", obs_rx_count, 32'd14);
        rx_ready = 1'b1;
        i = 0;
        while (rx_taken - base <= 4 && i < 20) begin tick(); i++; end
        check_val("bp_restart", {31'd0, rx_taken - base > 4}, 32'd1);
        rx_supplied = rx_taken;
        wait_idle("bp_idle", 20);
        repeat (6) tick();
        check_val("bp_drained", {31'd0, obs_rx_valid}, 32'd0);

        // Write stall: space for two of three words.
        tx_space = tx_taken + 2;
        tx_total = tx_sent + 3;
        i = 0;
        while (obs_tx_count != 32'd2 && i < 10) begin tick(); i++; end
        check_val("ws_two_sent", obs_tx_count, 32'd2);
        tick();
        check_val("ws_wr_n", {31'd0, obs_wr_n}, 32'd1);
        check_val("ws_pending", tx_total - tx_sent, 32'd1);
        tx_space = tx_taken + 1;
        i = 0;
        while (tx_sent != tx_total && i < 10) begin tick(); i++; end
        wait_idle("ws_idle", 10);
        check_val("ws_total", obs_tx_count, 32'd3);

        // Counter wrap from all-ones.
        force u_dut.tx_count_q = 32'hFFFF_FFFF;
        tick();
        release u_dut.tx_count_q;
        tx_space = tx_taken + 1;
        tx_total = tx_sent + 1;
        i = 0;
        while (tx_sent != tx_total && i < 10) begin tick(); i++; end
        wait_idle("wrap_idle", 10);
        check_val("tx_wrap", obs_tx_count, 32'd0);

        // Reset in the middle of a 10-word read.
        nrst = 1'b0; repeat (2) tick(); nrst = 1'b1; tick();
        base = rx_taken;
        rx_supplied = base + 10;
        i = 0;
        while (rx_taken - base != 5 && i < 20) begin tick(); i++; end
        check_val("mr_five", rx_taken - base, 32'd5);
        nrst = 1'b0;
        tick();
        check_val("mr_oe_n", {31'd0, obs_oe_n}, 32'd1);
        check_val("mr_wr_n", {31'd0, obs_wr_n}, 32'd1);
        check_val("mr_rx_valid", {31'd0, obs_rx_valid}, 32'd0);
        check_val("mr_rx_count", obs_rx_count, 32'd0);
        check_val("mr_tx_count", obs_tx_count, 32'd0);
        check_val("mr_busy", {31'd0, obs_busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check_val("mr_rd_n", {31'd0, obs_rd_n}, 32'd1);
            tick();
        end
        rx_supplied = rx_taken;
        nrst = 1'b1;
        tick();

        // Contention with MAX_BURST=4: grants alternate starting with read.
        nrst = 1'b0; use4 = 1'b1;
        repeat (2) tick();
        rx_supplied = rx_taken + 1000;
        tx_space = tx_taken + 1000;
        tx_total = tx_sent + 1000;
        rx_ready = 1'b1;
        cont_chk = 1'b1;
        nrst = 1'b1;
        i = 0;
        while (n_bursts < 6 && i < 200) begin tick(); i++; end
        check_val("cont_bursts", {31'd0, n_bursts >= 6}, 32'd1);
        cont_chk = 1'b0;
        rx_supplied = rx_taken;
        tx_total = tx_sent;
        wait_idle("cont_idle", 20);
        repeat (8) tick();
        check_val("sb_rx_empty", rx_exp.size(), 32'd0);
        check_val("sb_tx_empty", tx_exp.size(), 32'd0);
        check_val("cont_rx_count", obs_rx_count, exp_rx_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
